// File: rtl/ale_pkg.sv
// ---------------------------------------------------------------------------
// ale_pkg
// Shared definitions for the atmospheric-light estimator:
//   - ale_state_e : controller states (ACCUM / DIVIDE / PUBLISH)
//   - MODE_*      : selection key used to pick the brightest candidate pixel
//   - key_width() : width of the selection key for a given mode
// ---------------------------------------------------------------------------
package ale_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,  // scanning pixels of the current frame
        ST_DIVIDE  = 2'd1,  // reciprocal dividers running
        ST_PUBLISH = 2'd2   // one cycle: results registered to the outputs
    } ale_state_e;

    // Selection key: minimum over channels (dark-channel maximum) or the
    // channel sum (brightness maximum).
    localparam int MODE_MAX_DARK = 0;
    localparam int MODE_MAX_SUM  = 1;

    // A channel minimum fits in DW bits; a sum of ch channels needs
    // clog2(ch) extra bits to hold ch * (2^dw - 1) without overflow.
    function automatic int key_width(input int dw, input int ch, input int mode);
        return (mode == MODE_MAX_SUM) ? dw + $clog2(ch) : dw;
    endfunction

endpackage

// File: rtl/ale_recip_div.sv
// ---------------------------------------------------------------------------
// ale_recip_div
// Restoring reciprocal divider: quot = floor(2^INV_W / divisor), saturated to
// 2^INV_W-1. One quotient bit per cycle, INV_W iterations after start.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : load divisor_i and begin a new division (restarts if busy)
//   divisor_i  : DW-bit divisor, sampled on the start edge
//   done_o     : one-cycle pulse, high the cycle after the last iteration
//   quot_o     : quotient; stable from done_o until the next start
// ---------------------------------------------------------------------------
module ale_recip_div #(
    parameter int DW    = 8,
    parameter int INV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DW-1:0]    divisor_i,
    output logic             done_o,
    output logic [INV_W-1:0] quot_o
);

    localparam int CNT_W = $clog2(INV_W + 1);

    logic [DW-1:0]    rem_q, rem_d;
    logic [DW-1:0]    div_q;
    logic [INV_W-1:0] quot_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             sat_q;
    logic             done_q;

    logic [DW:0]      trial;
    logic             fits;

    // The dividend is a 1 followed by INV_W zeros. For divisor >= 2 the
    // leading 1 never fits, so the remainder starts at 1 and the remaining
    // INV_W steps each bring down a 0. A borrow out of the trial subtraction
    // (trial[DW]) means the shifted remainder was smaller than the divisor.
    always_comb begin
        trial = {rem_q, 1'b0} - {1'b0, div_q};
        fits  = ~trial[DW];
        rem_d = fits ? trial[DW-1:0] : {rem_q[DW-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking (<=) so every
        // register in this block samples the values from before the edge.
        if (rst) begin
            rem_q  <= '0;
            div_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            sat_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q  <= DW'(1);
                div_q  <= divisor_i;
                quot_q <= '0;
                cnt_q  <= CNT_W'(INV_W);
                busy_q <= 1'b1;
                // 2^INV_W / 1 (or / 0) does not fit in INV_W bits.
                sat_q  <= (divisor_i <= DW'(1));
            end else if (busy_q) begin
                rem_q  <= rem_d;
                quot_q <= {quot_q[INV_W-2:0], fits};
                cnt_q  <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign quot_o = sat_q ? '1 : quot_q;

endmodule

// File: rtl/ale_stream_param.sv
// ---------------------------------------------------------------------------
// ale_stream_param
// Streaming atmospheric-light estimator. Over each IMG_W*IMG_H frame it keeps
// the pixel with the largest key (channel minimum or channel sum, first
// maximum wins), clamps each channel to at least A_MIN, computes per-channel
// reciprocals 2^INV_W / A, and publishes both with a one-cycle ale_valid.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   input_pixel     : CH*DW pixel, channel k at [k*DW +: DW]
//   input_is_valid  : pixel qualifier
//   input_sof       : start of frame (qualified by input_is_valid)
//   input_ready     : high while scanning; pixel accepted on valid && ready
//   a_out           : clamped atmospheric light, same packing as input_pixel
//   inv_a           : reciprocals, channel k at [k*INV_W +: INV_W]
//   ale_valid       : one-cycle pulse when a_out/inv_a are updated
// ---------------------------------------------------------------------------
module ale_stream_param
    import ale_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CH    = 3,
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int INV_W = 16,
    parameter int MODE  = 0,
    parameter int A_MIN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*DW-1:0]    input_pixel,
    input  logic                input_is_valid,
    input  logic                input_sof,
    output logic                input_ready,
    output logic [CH*DW-1:0]    a_out,
    output logic [CH*INV_W-1:0] inv_a,
    output logic                ale_valid
);

    localparam int            NPIX    = IMG_W * IMG_H;
    localparam int            CW      = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int            KW      = key_width(DW, CH, MODE);
    localparam logic [DW-1:0] A_MIN_V = DW'(A_MIN);

    // Controller
    ale_state_e state_q, state_d;
    logic       publish;

    // Frame scan
    logic [CW-1:0]    cnt_q;
    logic             first_q;
    logic [CH*DW-1:0] cand_pix_q;
    logic [KW-1:0]    cand_key_q;

    // Outputs
    logic [CH*DW-1:0]    a_out_q;
    logic [CH*INV_W-1:0] inv_a_q;
    logic                ale_valid_q;

    // Combinational helpers
    logic [DW-1:0]       key_min;
    logic [KW-1:0]       key_sum;
    logic [KW-1:0]       pix_key;
    logic                accept;
    logic [CW-1:0]       pos;
    logic                frame_first;
    logic                frame_last;
    logic                frame_done;
    logic                take;
    logic [CH*DW-1:0]    cand_pix_nxt;
    logic [CH*DW-1:0]    div_a;
    logic [CH*DW-1:0]    pub_a;
    logic [CH-1:0]       div_done;
    logic [CH*INV_W-1:0] quot;
    logic                all_done;

    // ------------------------------------------------------------------
    // Selection key of the incoming pixel
    // ------------------------------------------------------------------
    always_comb begin
        key_min = '1;
        key_sum = '0;
        for (int k = 0; k < CH; k++) begin
            if (input_pixel[k*DW +: DW] < key_min) begin
                key_min = input_pixel[k*DW +: DW];
            end
            key_sum = key_sum + KW'(input_pixel[k*DW +: DW]);
        end
        pix_key = (MODE == MODE_MAX_SUM) ? key_sum : KW'(key_min);
    end

    // ------------------------------------------------------------------
    // Frame bookkeeping. A start-of-frame pixel restarts the scan at
    // position 0 whatever the counter says, dropping any partial frame.
    // ------------------------------------------------------------------
    assign accept       = input_is_valid && input_ready;
    assign pos          = input_sof ? '0 : cnt_q;
    assign frame_first  = input_sof || first_q;
    assign frame_last   = (pos == CW'(NPIX - 1));
    assign frame_done   = accept && frame_last;
    assign take         = frame_first || (pix_key > cand_key_q);

    // Candidate as it will be after this edge; the dividers start on the
    // same edge that accepts the last pixel, so they need this look-ahead.
    assign cand_pix_nxt = (accept && take) ? input_pixel : cand_pix_q;

    // ------------------------------------------------------------------
    // Per-channel clamp and reciprocal dividers
    // ------------------------------------------------------------------
    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [DW-1:0] nxt_c;
        logic [DW-1:0] cur_c;

        assign nxt_c = cand_pix_nxt[k*DW +: DW];
        assign cur_c = cand_pix_q[k*DW +: DW];
        assign div_a[k*DW +: DW] = (nxt_c < A_MIN_V) ? A_MIN_V : nxt_c;
        assign pub_a[k*DW +: DW] = (cur_c < A_MIN_V) ? A_MIN_V : cur_c;

        ale_recip_div #(
            .DW    (DW),
            .INV_W (INV_W)
        ) u_div (
            .clk       (clk),
            .rst       (rst),
            .start_i   (frame_done),
            .divisor_i (div_a[k*DW +: DW]),
            .done_o    (div_done[k]),
            .quot_o    (quot[k*INV_W +: INV_W])
        );
    end

    // All dividers start together and take the same number of cycles.
    assign all_done = &div_done;

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Controller: next state
    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves
        // state_d unassigned and a latch cannot be inferred.
        state_d = state_q;
        unique case (state_q)
            ST_ACCUM:   if (frame_done) state_d = ST_DIVIDE;
            ST_DIVIDE:  if (all_done)   state_d = ST_PUBLISH;
            ST_PUBLISH:                 state_d = ST_ACCUM;
            default:                    state_d = ST_ACCUM;
        endcase
    end

    // Controller: outputs
    always_comb begin
        input_ready = 1'b0;
        publish     = 1'b0;
        unique case (state_q)
            ST_ACCUM:   input_ready = 1'b1;
            ST_PUBLISH: publish     = 1'b1;
            default:    ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            first_q     <= 1'b1;
            cand_pix_q  <= '0;
            cand_key_q  <= '0;
            a_out_q     <= '0;
            inv_a_q     <= '0;
            ale_valid_q <= 1'b0;
        end else begin
            ale_valid_q <= 1'b0;

            if (accept) begin
                cnt_q   <= frame_last ? '0 : pos + 1'b1;
                first_q <= frame_last;
                if (take) begin
                    cand_pix_q <= input_pixel;
                    cand_key_q <= pix_key;
                end
            end

            // The candidate is frozen while not scanning, so pub_a equals the
            // divisors the quotients were computed from.
            if (publish) begin
                a_out_q     <= pub_a;
                inv_a_q     <= quot;
                ale_valid_q <= 1'b1;
            end
        end
    end

    assign a_out     = a_out_q;
    assign inv_a     = inv_a_q;
    assign ale_valid = ale_valid_q;

endmodule

// File: tb/tb_ale_stream_param.sv
// ---------------------------------------------------------------------------
// tb_ale_stream_param
// Two instances on shared stimulus (MODE 0 and MODE 1), 4x4 frames. Fixed
// vectors carry hand-derived results; random frames are scored against a
// reference that picks the first maximum-key pixel and divides directly.
// ---------------------------------------------------------------------------
module tb_ale_stream_param;

    localparam int DW    = 8;
    localparam int CH    = 3;
    localparam int IW    = 4;
    localparam int IH    = 4;
    localparam int INV_W = 16;
    localparam int NP    = IW * IH;
    localparam int LAT   = INV_W + 2;

    typedef struct packed {
        logic [23:0] bg;
        logic [3:0]  i1;
        logic [23:0] p1;
        logic [3:0]  i2;
        logic [23:0] p2;
        logic [23:0] a0;
        logic [47:0] inv0;
        logic [23:0] a1;
        logic [47:0] inv1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] pix = '0;
    logic        vld = 1'b0;
    logic        sof = 1'b0;

    logic        rdy0, av0, rdy1, av1;
    logic [23:0] a0, a1;
    logic [47:0] inv0, inv1;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses0 = 0;
    int pulses1 = 0;

    always #5 clk = ~clk;

    ale_stream_param #(
        .DW(DW), .CH(CH), .IMG_W(IW), .IMG_H(IH), .INV_W(INV_W), .MODE(0), .A_MIN(1)
    ) dut0 (
        .clk(clk), .rst(rst), .input_pixel(pix), .input_is_valid(vld),
        .input_sof(sof), .input_ready(rdy0), .a_out(a0), .inv_a(inv0),
        .ale_valid(av0)
    );

    ale_stream_param #(
        .DW(DW), .CH(CH), .IMG_W(IW), .IMG_H(IH), .INV_W(INV_W), .MODE(1), .A_MIN(1)
    ) dut1 (
        .clk(clk), .rst(rst), .input_pixel(pix), .input_is_valid(vld),
        .input_sof(sof), .input_ready(rdy1), .a_out(a1), .inv_a(inv1),
        .ale_valid(av1)
    );

    always @(negedge clk) begin
        if (av0) pulses0++;
        if (av1) pulses1++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: first pixel with the strictly largest key, per-channel
    // clamp to 1, reciprocal by integer division with saturation.
    function automatic logic [71:0] model(input logic [NP*24-1:0] fr, input int mode);
        int          best_key;
        int          key;
        int          av;
        int          q;
        logic [23:0] best;
        logic [23:0] p;
        logic [23:0] a;
        logic [47:0] inv;
        best_key = -1;
        best     = '0;
        a        = '0;
        inv      = '0;
        for (int i = 0; i < NP; i++) begin
            p = fr[i*24 +: 24];
            if (mode == 1) begin
                key = int'(p[7:0]) + int'(p[15:8]) + int'(p[23:16]);
            end else begin
                key = int'(p[7:0]);
                if (int'(p[15:8])  < key) key = int'(p[15:8]);
                if (int'(p[23:16]) < key) key = int'(p[23:16]);
            end
            if (key > best_key) begin
                best_key = key;
                best     = p;
            end
        end
        for (int k = 0; k < CH; k++) begin
            av = int'(best[k*8 +: 8]);
            if (av < 1) av = 1;
            q = 65536 / av;
            if (q > 65535) q = 65535;
            a[k*8 +: 8]    = 8'(av);
            inv[k*16 +: 16] = 16'(q);
        end
        return {a, inv};
    endfunction

    function automatic logic [NP*24-1:0] build(input vec_t v);
        logic [NP*24-1:0] fr;
        for (int i = 0; i < NP; i++) fr[i*24 +: 24] = v.bg;
        fr[v.i1*24 +: 24] = v.p1;
        fr[v.i2*24 +: 24] = v.p2;
        return fr;
    endfunction

    function automatic logic [23:0] rnd_pix();
        if ($urandom_range(0, 1) == 1) return 24'($urandom);
        return {8'($urandom_range(0, 4) * 50), 8'($urandom_range(0, 4) * 50),
                8'($urandom_range(0, 4) * 50)};
    endfunction

    function automatic logic [NP*24-1:0] rnd_frame();
        logic [NP*24-1:0] fr;
        for (int i = 0; i < NP; i++) fr[i*24 +: 24] = rnd_pix();
        return fr;
    endfunction

    // Presents npix pixels; idle gaps carry junk with sof set but valid low.
    task automatic send_frame(input logic [NP*24-1:0] fr, input int npix,
                              input bit sof_first, input bit gaps, input bit hold);
        for (int i = 0; i < npix; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    vld = 1'b0; sof = 1'b1; pix = 24'hFFFFFF;
                    @(posedge clk); #1;
                end
            end
            pix = fr[i*24 +: 24];
            vld = 1'b1;
            sof = sof_first && (i == 0);
            @(posedge clk); #1;
        end
        sof = 1'b0;
        if (hold) begin
            vld = 1'b1;
            pix = 24'hFFFFFF;
        end else begin
            vld = 1'b0;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Called #1 after the edge that accepted the last pixel of a frame.
    task automatic wait_result(input string name, input logic [71:0] e0, input logic [71:0] e1);
        int n;
        int p0;
        int p1;
        p0 = pulses0;
        p1 = pulses1;
        n  = 0;
        check({name, " ready low in divide"}, 72'({rdy0, rdy1}), 72'(0));
        for (int i = 1; i <= LAT + 20; i++) begin
            @(posedge clk); #1;
            if (av0 || av1) begin
                n = i;
                break;
            end
        end
        vld = 1'b0;
        check({name, " latency"}, 72'(n), 72'(LAT));
        check({name, " both pulse"}, 72'({av0, av1}), 72'(2'b11));
        check({name, " mode0 a/inv"}, {a0, inv0}, e0);
        check({name, " mode1 a/inv"}, {a1, inv1}, e1);
        @(posedge clk); #1;
        check({name, " pulse one cycle"}, 72'({av0, av1}), 72'(0));
        check({name, " pulse count"}, 72'({16'(pulses0 - p0), 16'(pulses1 - p1)}),
              72'({16'd1, 16'd1}));
    endtask

    initial begin
        vec_t             tbl [8];
        logic [NP*24-1:0] fr;
        logic [NP*24-1:0] junk;
        int               p0s;
        int               p1s;

        tbl[0] = '{24'h101010, 4'd5, 24'hC8D2DC, 4'd5, 24'hC8D2DC,
                   24'hC8D2DC, {16'd327, 16'd312, 16'd297},
                   24'hC8D2DC, {16'd327, 16'd312, 16'd297}};
        tbl[1] = '{24'h101010, 4'd2, 24'h8090A0, 4'd9, 24'h80FFFF,
                   24'h8090A0, {16'd512, 16'd455, 16'd409},
                   24'h80FFFF, {16'd512, 16'd257, 16'd257}};
        tbl[2] = '{24'h000000, 4'd3, 24'hFF0000, 4'd7, 24'h606060,
                   24'h606060, {16'd682, 16'd682, 16'd682},
                   24'h606060, {16'd682, 16'd682, 16'd682}};
        tbl[3] = '{24'h000000, 4'd0, 24'h000000, 4'd0, 24'h000000,
                   24'h010101, {16'd65535, 16'd65535, 16'd65535},
                   24'h010101, {16'd65535, 16'd65535, 16'd65535}};
        tbl[4] = '{24'h101010, 4'd1, 24'h20FF20, 4'd12, 24'h303030,
                   24'h303030, {16'd1365, 16'd1365, 16'd1365},
                   24'h20FF20, {16'd2048, 16'd257, 16'd2048}};
        tbl[5] = '{24'h000000, 4'd7, 24'h00FF02, 4'd7, 24'h00FF02,
                   24'h010101, {16'd65535, 16'd65535, 16'd65535},
                   24'h01FF02, {16'd65535, 16'd257, 16'd32768}};
        tbl[6] = '{24'h111111, 4'd15, 24'hFEFEFE, 4'd15, 24'hFEFEFE,
                   24'hFEFEFE, {16'd258, 16'd258, 16'd258},
                   24'hFEFEFE, {16'd258, 16'd258, 16'd258}};
        tbl[7] = '{24'h505050, 4'd0, 24'h707070, 4'd15, 24'h70FF70,
                   24'h707070, {16'd585, 16'd585, 16'd585},
                   24'h70FF70, {16'd585, 16'd257, 16'd585}};

        for (int i = 0; i < NP; i++) junk[i*24 +: 24] = 24'hFFFFFF;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset mode0 a/inv", {a0, inv0}, 72'(0));
        check("reset mode1 a/inv", {a1, inv1}, 72'(0));
        check("reset valid/ready", 72'({av0, rdy0, av1, rdy1}), 72'(4'b0101));

        // Fixed vectors
        for (int t = 0; t < 8; t++) begin
            send_frame(build(tbl[t]), NP, 1'b1, 1'b0, 1'b0);
            wait_result($sformatf("vec%0d", t), {tbl[t].a0, tbl[t].inv0},
                        {tbl[t].a1, tbl[t].inv1});
        end

        // Start of frame mid-frame abandons the partial frame; pixels held
        // valid during the divide are ignored.
        p0s = pulses0;
        p1s = pulses1;
        send_frame(junk, 10, 1'b1, 1'b0, 1'b0);
        fr = build('{24'h202020, 4'd6, 24'h405060, 4'd6, 24'h405060,
                     24'h0, 48'h0, 24'h0, 48'h0});
        send_frame(fr, NP, 1'b1, 1'b0, 1'b1);
        wait_result("sof restart", model(fr, 0), model(fr, 1));
        check("sof restart single pulse", 72'({16'(pulses0 - p0s), 16'(pulses1 - p1s)}),
              72'({16'd1, 16'd1}));
        fr = rnd_frame();
        send_frame(fr, NP, 1'b0, 1'b0, 1'b0);
        wait_result("after held pixels", model(fr, 0), model(fr, 1));

        // Reset during the divide: no pulse, outputs cleared
        fr = rnd_frame();
        send_frame(fr, NP, 1'b1, 1'b0, 1'b0);
        p0s = pulses0;
        p1s = pulses1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        pulse_rst();
        repeat (30) begin
            @(posedge clk); #1;
        end
        check("divide abort no pulse", 72'({16'(pulses0 - p0s), 16'(pulses1 - p1s)}), 72'(0));
        check("divide abort mode0 cleared", {a0, inv0}, 72'(0));
        check("divide abort mode1 cleared", {a1, inv1}, 72'(0));
        check("divide abort ready", 72'({rdy0, rdy1}), 72'(2'b11));
        fr = rnd_frame();
        send_frame(fr, NP, 1'b1, 1'b0, 1'b0);
        wait_result("after divide abort", model(fr, 0), model(fr, 1));

        // Reset mid-frame, then a full frame without start-of-frame marker
        send_frame(junk, 8, 1'b1, 1'b0, 1'b0);
        pulse_rst();
        fr = rnd_frame();
        send_frame(fr, NP, 1'b0, 1'b0, 1'b0);
        wait_result("after midframe reset", model(fr, 0), model(fr, 1));

        // Random frames with idle gaps
        for (int r = 0; r < 20; r++) begin
            fr = rnd_frame();
            send_frame(fr, NP, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            wait_result($sformatf("rand%0d", r), model(fr, 0), model(fr, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
